// File: rtl/puf_eval_seq.sv
// PUF evaluation sequencer: sweeps every array address, runs VOTES clear/settle/sample
// passes per address and hands out a majority-voted word with a stability flag.
//
// state  | meaning
// IDLE   | array held in reset, waiting for go
// CLR    | 2-cycle array clear before each evaluation
// ARM    | START held high for SETTLE_CYCLES while the array settles
// SAMPLE | START still high, puf_data folded into the per-bit vote counters
// OUT    | voted word presented on resp_*, waiting for resp_ready
// FIN    | one-cycle done pulse, then back to IDLE
module puf_eval_seq #(
  parameter int ADDR_BITS     = 4,
  parameter int OUT_BITS      = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int VOTES         = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  output logic                 busy,
  output logic                 puf_rst,
  output logic                 puf_start,
  output logic [ADDR_BITS-1:0] puf_addr,
  input  logic [OUT_BITS-1:0]  puf_data,
  output logic [OUT_BITS-1:0]  resp_data,
  output logic [ADDR_BITS-1:0] resp_addr,
  output logic                 resp_stable,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 done
);

  typedef enum logic [2:0] {IDLE, CLR, ARM, SAMPLE, OUT, FIN} state_t;

  localparam logic [7:0]           SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]           CLR_LOAD    = 8'd1;
  localparam logic [2:0]           VOTES_N     = 3'(VOTES);
  localparam logic [2:0]           MAJ_TH      = 3'(VOTES / 2);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST   = '1;

  state_t              state;
  logic [7:0]          timer;
  logic [2:0]          votes_done;
  logic [2:0]          cnt     [OUT_BITS];
  logic [2:0]          cnt_sum [OUT_BITS];
  logic [OUT_BITS-1:0] maj_word;
  logic                all_agree;
  logic                last_vote;

  // Counters including the sample being taken this cycle, so OUT sees the final tally.
  always_comb begin
    all_agree = 1'b1;
    maj_word  = '0;
    cnt_sum   = '{default: 3'd0};
    for (int i = 0; i < OUT_BITS; i++) begin
      cnt_sum[i]  = cnt[i] + {2'b00, puf_data[i]};
      maj_word[i] = (cnt_sum[i] > MAJ_TH);
      if ((cnt_sum[i] != 3'd0) && (cnt_sum[i] != VOTES_N)) begin
        all_agree = 1'b0;
      end
    end
  end

  assign last_vote = (votes_done == (VOTES_N - 3'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      votes_done  <= '0;
      busy        <= 1'b0;
      puf_rst     <= 1'b1;
      puf_start   <= 1'b0;
      puf_addr    <= '0;
      resp_data   <= '0;
      resp_addr   <= '0;
      resp_stable <= 1'b0;
      resp_valid  <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < OUT_BITS; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          puf_rst    <= 1'b1;
          puf_start  <= 1'b0;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
          done       <= 1'b0;
          if (go) begin
            state      <= CLR;
            timer      <= CLR_LOAD;
            puf_addr   <= '0;
            votes_done <= '0;
            busy       <= 1'b1;
            for (int i = 0; i < OUT_BITS; i++) cnt[i] <= '0;
          end
        end

        CLR: begin
          if (timer == 8'd0) begin
            state     <= ARM;
            timer     <= SETTLE_LOAD;
            puf_rst   <= 1'b0;
            puf_start <= 1'b1;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        ARM: begin
          if (timer == 8'd0) begin
            state <= SAMPLE;
          end else begin
            timer <= timer - 8'd1;
          end
        end

        SAMPLE: begin
          for (int i = 0; i < OUT_BITS; i++) cnt[i] <= cnt_sum[i];
          votes_done <= votes_done + 3'd1;
          puf_rst    <= 1'b1;
          puf_start  <= 1'b0;
          if (last_vote) begin
            state       <= OUT;
            resp_data   <= maj_word;
            resp_stable <= all_agree;
            resp_addr   <= puf_addr;
            resp_valid  <= 1'b1;
          end else begin
            state <= CLR;
            timer <= CLR_LOAD;
          end
        end

        OUT: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            votes_done <= '0;
            for (int i = 0; i < OUT_BITS; i++) cnt[i] <= '0;
            // The last address finishes the sweep instead of wrapping.
            if (puf_addr != ADDR_LAST) begin
              state    <= CLR;
              timer    <= CLR_LOAD;
              puf_addr <= puf_addr + 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end

        FIN: begin
          state    <= IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          puf_addr <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_seq.sv
// Bench for puf_eval_seq: a VOTES=3 instance checked against a majority-vote model
// every cycle, plus a VOTES=1 instance for single-evaluation timing and stability.
module tb_puf_eval_seq;

  localparam int AB  = 4;
  localparam int OB  = 8;
  localparam int S   = 4;
  localparam int V   = 3;
  localparam int PER = V * (3 + S);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0, go1 = 1'b0, resp_ready = 1'b0;
  logic          busy, puf_rst, puf_start, resp_stable, resp_valid, done;
  logic [AB-1:0] puf_addr, resp_addr;
  logic [OB-1:0] puf_data = '0, resp_data;

  logic          busy1, puf_rst1, puf_start1, resp_stable1, resp_valid1, done1;
  logic [AB-1:0] puf_addr1, resp_addr1;
  logic [OB-1:0] puf_data1, resp_data1;

  always #5 clk = ~clk;

  puf_eval_seq #(.ADDR_BITS(AB), .OUT_BITS(OB), .SETTLE_CYCLES(S), .VOTES(V)) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .puf_rst(puf_rst),
    .puf_start(puf_start), .puf_addr(puf_addr), .puf_data(puf_data),
    .resp_data(resp_data), .resp_addr(resp_addr), .resp_stable(resp_stable),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .done(done));

  puf_eval_seq #(.ADDR_BITS(AB), .OUT_BITS(OB), .SETTLE_CYCLES(S), .VOTES(1)) dut1 (
    .clk(clk), .reset(reset), .go(go1), .busy(busy1), .puf_rst(puf_rst1),
    .puf_start(puf_start1), .puf_addr(puf_addr1), .puf_data(puf_data1),
    .resp_data(resp_data1), .resp_addr(resp_addr1), .resp_stable(resp_stable1),
    .resp_valid(resp_valid1), .resp_ready(1'b1), .done(done1));

  assign puf_data1 = {4'hC, puf_addr1};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Array response for (mode, address, evaluation index).
  int mode = 0;
  function automatic logic [7:0] pat(input int m, input int a, input int v);
    case (m)
      0:       return 8'hA5;
      1:       return (v == 0) ? 8'h0F : ((v == 1) ? 8'hFF : 8'h00);
      default: return 8'(a * 37 + v * 91);
    endcase
  endfunction

  // {stable, word}: majority of V evaluations, stable when every bit is unanimous.
  function automatic logic [8:0] model_resp(input int m, input int a);
    logic [7:0] w;
    logic [7:0] p;
    logic       st;
    w  = '0;
    st = 1'b1;
    for (int b = 0; b < 8; b++) begin
      int ones;
      ones = 0;
      for (int v = 0; v < V; v++) begin
        p = pat(m, a, v);
        if (p[b]) ones++;
      end
      if (ones * 2 > V) w[b] = 1'b1;
      if (ones != 0 && ones != V) st = 1'b0;
    end
    return {st, w};
  endfunction

  // Array model: a new evaluation's value appears at the start of each ARM phase.
  logic start_prev_d = 1'b0;
  int   arm_idx = 0;
  always @(negedge clk) begin
    if (reset || resp_valid) begin
      arm_idx = 0;
    end else if (puf_start && !start_prev_d) begin
      puf_data = pat(mode, int'(puf_addr), arm_idx);
      arm_idx++;
    end
    start_prev_d = puf_start;
  end

  int         exp_addr = 0, resp_cnt = 0, done_cnt = 0, start_run = 0, last_rise = -1, cyc = 0;
  logic       prev_valid = 1'b0, prev_done = 1'b0, bp = 1'b0;
  logic [7:0] held_data;
  logic [3:0] held_addr;
  logic       held_stable;
  logic [8:0] m_resp;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_addr = 0; start_run = 0; prev_valid = 1'b0; prev_done = 1'b0;
      bp = 1'b0; last_rise = -1;
    end else begin
      if (puf_start || resp_valid) chk("busy_active", 32'(busy), 32'd1);
      if (puf_start) begin
        start_run++;
        chk("arm_rst_low", 32'(puf_rst), 32'd0);
        chk("arm_addr", 32'(puf_addr), 32'(exp_addr));
      end else if (start_run != 0) begin
        chk("start_len", 32'(start_run), 32'(S + 1));
        start_run = 0;
      end
      if (resp_valid) begin
        chk("out_start", 32'(puf_start), 32'd0);
        chk("out_rst", 32'(puf_rst), 32'd1);
        chk("out_puf_addr", 32'(puf_addr), 32'(exp_addr));
        if (!prev_valid) begin
          m_resp = model_resp(mode, exp_addr);
          chk("resp_addr", 32'(resp_addr), 32'(exp_addr));
          chk("resp_data", 32'(resp_data), 32'(m_resp[7:0]));
          chk("resp_stable", 32'(resp_stable), 32'(m_resp[8]));
          if (last_rise >= 0 && !bp) chk("resp_gap", 32'(cyc - last_rise), 32'(PER + 1));
          last_rise   = cyc;
          bp          = 1'b0;
          held_data   = resp_data;
          held_addr   = resp_addr;
          held_stable = resp_stable;
        end else begin
          chk("hold_data", 32'(resp_data), 32'(held_data));
          chk("hold_addr", 32'(resp_addr), 32'(held_addr));
          chk("hold_stable", 32'(resp_stable), 32'(held_stable));
        end
        if (!resp_ready) bp = 1'b1;
        else begin
          resp_cnt++;
          exp_addr++;
        end
      end
      if (done) begin
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_width", 32'(prev_done), 32'd0);
        chk("done_after_all", 32'(exp_addr), 32'd16);
        done_cnt++;
        exp_addr  = 0;
        last_rise = -1;
      end
      prev_valid = resp_valid;
      prev_done  = done;
    end
  end

  int exp_addr1 = 0, resp_cnt1 = 0, done_cnt1 = 0, last1 = -1, cyc1 = 0;
  always @(negedge clk) begin
    cyc1++;
    if (reset) begin
      exp_addr1 = 0; last1 = -1;
    end else begin
      if (resp_valid1) begin
        chk("v1_stable", 32'(resp_stable1), 32'd1);
        chk("v1_addr", 32'(resp_addr1), 32'(exp_addr1));
        chk("v1_data", 32'(resp_data1), 32'(8'hC0 | 8'(exp_addr1)));
        if (last1 >= 0) chk("v1_gap", 32'(cyc1 - last1), 32'(3 + S + 1));
        last1 = cyc1;
        resp_cnt1++;
        exp_addr1++;
      end
      if (done1) begin
        done_cnt1++;
        exp_addr1 = 0;
        last1     = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int k);
    k = 0;
    while (!resp_valid && k < budget) begin
      tick();
      k++;
    end
    chk("valid_seen", 32'(resp_valid), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    #1 reset = 1'b1;
    #2;
    chk("rst_puf_rst", 32'(puf_rst), 32'd1);
    chk("rst_puf_start", 32'(puf_start), 32'd0);
    chk("rst_puf_addr", 32'(puf_addr), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_addr", 32'(resp_addr), 32'd0);
    chk("rst_resp_stable", 32'(resp_stable), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Constant 0xA5, no back-pressure; both instances sweep.
    mode = 0;
    resp_ready = 1'b1;
    go  = 1'b1;
    go1 = 1'b1;
    tick();
    go  = 1'b0;
    go1 = 1'b0;
    wait_valid(200, k);
    chk("first_latency", 32'(k), 32'd21);
    chk("lit_a5_data", 32'(resp_data), 32'hA5);
    chk("lit_a5_stable", 32'(resp_stable), 32'd1);
    wait_done(2000);
    tick();
    chk("sweep1_busy_after", 32'(busy), 32'd0);
    chk("sweep1_puf_addr", 32'(puf_addr), 32'd0);
    chk("sweep1_resp_cnt", 32'(resp_cnt), 32'd16);
    chk("sweep1_done_cnt", 32'(done_cnt), 32'd1);
    chk("v1_resp_cnt", 32'(resp_cnt1), 32'd16);
    chk("v1_done_cnt", 32'(done_cnt1), 32'd1);
    chk("v1_busy_after", 32'(busy1), 32'd0);

    // Disagreeing evaluations, with back-pressure on address 0.
    mode = 1;
    resp_ready = 1'b0;
    pulse_go();
    wait_valid(200, k);
    chk("lit_0f_data", 32'(resp_data), 32'h0F);
    chk("lit_0f_stable", 32'(resp_stable), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", 32'(resp_data), 32'h0F);
      chk("bp_start", 32'(puf_start), 32'd0);
      chk("bp_addr", 32'(puf_addr), 32'd0);
    end
    resp_ready = 1'b1;
    wait_done(2000);
    tick();
    chk("sweep2_resp_cnt", 32'(resp_cnt), 32'd32);
    chk("sweep2_done_cnt", 32'(done_cnt), 32'd2);

    // Address-dependent data; go pulses in ARM and OUT must be ignored.
    mode = 2;
    pulse_go();
    k = 0;
    while (!puf_start && k < 50) begin
      tick();
      k++;
    end
    chk("arm_reached", 32'(puf_start), 32'd1);
    pulse_go();
    wait_valid(200, k);
    chk("lit_m2_data", 32'(resp_data), 32'h12);
    chk("lit_m2_stable", 32'(resp_stable), 32'd0);
    pulse_go();
    wait_done(2000);
    repeat (5) tick();
    chk("sweep3_busy_after", 32'(busy), 32'd0);
    chk("sweep3_resp_cnt", 32'(resp_cnt), 32'd48);
    chk("sweep3_done_cnt", 32'(done_cnt), 32'd3);

    // Abort during ARM of address 5, then restart from address 0.
    mode = 0;
    pulse_go();
    k = 0;
    while (!(exp_addr == 5 && puf_start) && k < 2000) begin
      tick();
      k++;
    end
    chk("addr5_arm_reached", 32'(puf_addr), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("abort_start", 32'(puf_start), 32'd0);
    chk("abort_rst", 32'(puf_rst), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_addr", 32'(puf_addr), 32'd0);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", 32'(done_cnt), 32'd3);
    pulse_go();
    wait_valid(200, k);
    chk("restart_addr", 32'(resp_addr), 32'd0);
    wait_done(2000);
    tick();
    chk("sweep4_done_cnt", 32'(done_cnt), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_eval_seq.md
PUF_EVAL_SEQ -- requirements
Module: puf_eval_seq

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 4, address width of the attached PUF array.
REQ-002 The block SHALL have parameter OUT_BITS, default 8, data width of the attached PUF array.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 16, number of cycles START is held high before sampling; legal range 2..255.
REQ-004 The block SHALL have parameter VOTES, default 3, number of evaluations per address; odd, legal range 1..7.
REQ-005 The block SHALL have the port clk, input, width 1, the system clock.
REQ-006 The block SHALL have the port reset, input, width 1, asynchronous active-high reset.
REQ-007 The block SHALL have the port go, input, width 1, which requests one full sweep.
REQ-008 The block SHALL have the port busy, output, width 1, which is high while a sweep is in progress.
REQ-009 The block SHALL have the port puf_rst, output, width 1, the clear signal to the array reset.
REQ-010 The block SHALL have the port puf_start, output, width 1, the drive to the array START.
REQ-011 The block SHALL have the port puf_addr, output, ADDR_BITS wide, the array read address.
REQ-012 The block SHALL have the port puf_data, input, OUT_BITS wide, the array's registered output (one-cycle latency from address).
REQ-013 The block SHALL have the port resp_data, output, OUT_BITS wide, the majority-voted response word.
REQ-014 The block SHALL have the port resp_addr, output, ADDR_BITS wide, the address of resp_data.
REQ-015 The block SHALL have the port resp_stable, output, width 1, which is 1 when all VOTES evaluations agreed on every bit.
REQ-016 The block SHALL have the port resp_valid, output, width 1, which qualifies resp_*.
REQ-017 The block SHALL have the port resp_ready, input, width 1, the consumer accept signal.
REQ-018 The block SHALL have the port done, output, width 1, a one-cycle pulse at sweep end.

Function
REQ-019 The block SHALL implement the FSM states IDLE, CLR, ARM, SAMPLE, OUT and FIN, with all outputs registered.
REQ-020 In IDLE, puf_rst SHALL be 1, puf_start 0, busy 0 and resp_valid 0; go=1 SHALL move the FSM to CLR with address 0, vote count 0 and all bit counters 0.
REQ-021 go SHALL be ignored in every state other than IDLE.
REQ-022 CLR SHALL last exactly 2 cycles with puf_rst=1 and puf_start=0, then the FSM SHALL move to ARM.
REQ-023 ARM SHALL last exactly SETTLE_CYCLES cycles with puf_rst=0 and puf_start=1, then the FSM SHALL move to SAMPLE.
REQ-024 In SAMPLE (1 cycle, puf_start=1), the block SHALL capture puf_data, and for each bit i whose value is 1 it SHALL increment the 3-bit counter cnt[i].
REQ-025 After SAMPLE, if fewer than VOTES evaluations are complete the FSM SHALL go to CLR; otherwise it SHALL go to OUT.
REQ-026 puf_addr SHALL remain constant from the first CLR to the last SAMPLE of an address.
REQ-027 On entry to OUT, resp_data[i] SHALL be 1 if cnt[i] > VOTES/2 (integer division); resp_stable SHALL be 1 if every cnt[i] is 0 or VOTES; resp_addr SHALL equal puf_addr; resp_valid SHALL be 1.
REQ-028 In OUT, puf_rst SHALL be 1 and puf_start 0.
REQ-029 resp_valid and resp_* SHALL hold stable until a cycle in which resp_valid and resp_ready are both 1.
REQ-030 On that handshake cycle, resp_valid SHALL drop the next cycle and the counters SHALL clear.
REQ-031 After the handshake, if puf_addr is less than 2**ADDR_BITS-1 the block SHALL increment puf_addr and go to CLR; otherwise it SHALL go to FIN.
REQ-032 puf_addr SHALL never wrap within a sweep.
REQ-033 FIN SHALL assert done=1 for exactly one cycle, then the FSM SHALL return to IDLE and set puf_addr to 0.
REQ-034 busy SHALL be 1 in CLR, ARM, SAMPLE, OUT and FIN.
REQ-035 Each address SHALL take exactly VOTES*(3+SETTLE_CYCLES) cycles from its first CLR to the OUT entry, excluding back-pressure.
REQ-036 resp_ready held at 1 in OUT SHALL complete the handshake in 1 cycle; resp_ready=1 outside OUT SHALL have no effect.

Reset
REQ-037 When reset is asserted, the block SHALL go asynchronously to IDLE with puf_rst=1, puf_start=0, puf_addr=0, resp_data=0, resp_addr=0, resp_stable=0, resp_valid=0, busy=0, done=0 and all counters at 0.
REQ-038 A reset mid-sweep SHALL abort the sweep with no done pulse, and the next go SHALL restart at address 0.

Verification
REQ-039 With VOTES=3, SETTLE_CYCLES=4 and puf_data fixed at 8'hA5, a go pulse with resp_ready=1 -> 16 responses, addr 0..15, each with data 8'hA5 and stable=1; responses spaced 21+1 cycles apart; one done pulse; busy low afterwards.
REQ-040 Per address, puf_data = 8'h0F, 8'hFF, 8'h00 across the 3 SAMPLEs -> resp_data=8'h0F, resp_stable=0.
REQ-041 resp_ready held 0 for 10 cycles in OUT -> resp_valid and resp_data stable for 10 cycles, puf_start=0 throughout, no address advance.
REQ-042 Reset asserted during ARM of address 5 -> immediately puf_start=0, puf_rst=1, busy=0, no done; the next go produces the first response at addr 0.
REQ-043 go pulsed during ARM and during OUT -> no effect; exactly 16 responses and one done.
REQ-044 VOTES=1 -> resp_stable=1 for every word; each address takes 3+SETTLE_CYCLES cycles to OUT.
